// File: rtl/inst_encoder.sv
// RV32I field-to-word encoder that streams packed instructions into IMEM at consecutive addresses.
// Optional immediate range rejection is enabled by defining INST_ENC_RANGE_CHECK_EN.
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              wr_en,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_imm,
  output logic              err_opcode,
  output logic              err_wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       enc;
  logic              op_ok;
  logic              imm_used;
  logic              beat_good;
  logic              accept;
  logic              wr_done;

  // B-type imm is in halfword units, so imm[0] is already byte-offset bit 1.
  always_comb begin
    enc      = '0;
    op_ok    = 1'b1;
    imm_used = 1'b0;
    case (opcode)
      7'b0110011: enc = {funct7, rs2, rs1, funct3, rd, opcode};
      7'b0000011, 7'b0010011: begin
        enc      = {imm[11:0], rs1, funct3, rd, opcode};
        imm_used = 1'b1;
      end
      7'b0100011: begin
        enc      = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        imm_used = 1'b1;
      end
      7'b1100011: begin
        enc      = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
        imm_used = 1'b1;
      end
      default: op_ok = 1'b0;
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  logic imm_ok;
  assign imm_ok    = (&imm[31:11]) | ~(|imm[31:11]);
  assign beat_good = op_ok && (!imm_used || imm_ok);

  always_ff @(posedge clk) begin
    if (rst)
      err_imm <= 1'b0;
    else if (state == IDLE && start)
      err_imm <= 1'b0;
    else if (accept && op_ok && imm_used && !imm_ok)
      err_imm <= 1'b1;
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^{imm[31:12], imm_used};
  assign beat_good     = op_ok;
  assign err_imm       = 1'b0;
`endif

  assign accept  = in_valid && in_ready;
  assign wr_done = wr_en && mem_ready;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  // DRAIN waits for the registered word itself to be gone, not just leaving.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (accept && in_last) next_state = DRAIN;
      DRAIN:   if (!wr_en) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN) && (!wr_en || mem_ready);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      err_opcode <= 1'b0;
      err_wrap   <= 1'b0;
    end else if (state == IDLE && start) begin
      addr       <= base_addr;
      word_count <= '0;
      err_opcode <= 1'b0;
      err_wrap   <= 1'b0;
    end else begin
      if (wr_done && word_count != COUNT_MAX)
        word_count <= word_count + 1'b1;
      if (accept && beat_good) begin
        wr_en   <= 1'b1;
        wr_addr <= addr;
        wr_data <= enc;
        addr    <= addr + 1'b1;
        if (&addr)
          err_wrap <= 1'b1;
      end else begin
        if (wr_done)
          wr_en <= 1'b0;
        if (accept && !op_ok)
          err_opcode <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: vector table stream plus hand-written stall, wrap and reset sequences.
// A second instance with ADDR_W=2 shares all inputs to exercise address wrap and count saturation.
module tb_inst_encoder;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
    logic        expWrite;
    logic [31:0] expData;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        mem_ready = 1'b1;

  logic        in_ready, wr_en, busy, done, err_imm, err_opcode, err_wrap;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  word_count;

  logic        in_ready2, wr_en2, busy2, done2, err_imm2, err_opcode2, err_wrap2;
  logic [1:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic [2:0]  word_count2;

  int assertCount = 0;
  int failCount = 0;

  vec_t vecs[6];
  vec_t v;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wr_en(wr_en), .mem_ready(mem_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .word_count(word_count),
    .err_imm(err_imm), .err_opcode(err_opcode), .err_wrap(err_wrap)
  );

  inst_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[1:0]),
    .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .wr_en(wr_en2), .mem_ready(mem_ready), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .busy(busy2), .done(done2), .word_count(word_count2),
    .err_imm(err_imm2), .err_opcode(err_opcode2), .err_wrap(err_wrap2)
  );

  function automatic vec_t mkVec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rdI, input logic [4:0] rs1I, input logic [4:0] rs2I,
                                 input logic [31:0] immI, input logic last, input logic expWrite,
                                 input logic [31:0] expData);
    vec_t r;
    r.opcode = op; r.f3 = f3; r.f7 = f7; r.rd = rdI; r.rs1 = rs1I; r.rs2 = rs2I;
    r.imm = immI; r.last = last; r.expWrite = expWrite; r.expData = expData;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic driveBeat(input vec_t b);
    opcode = b.opcode; funct3 = b.f3; funct7 = b.f7;
    rd = b.rd; rs1 = b.rs1; rs2 = b.rs2; imm = b.imm;
    in_last = b.last;
    in_valid = 1'b1;
  endtask

  task automatic startSession(input logic [7:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  // Presents one beat, waits (bounded) for acceptance, returns just after the accepting edge.
  task automatic applyStimulus(input vec_t b);
    int n;
    driveBeat(b);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int pulses;
    pulses = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      if (done) pulses++;
      tick();
    end
    checkOutput({name, "_busy_clear"}, {31'd0, busy}, 32'd0);
    checkOutput({name, "_done_pulses"}, pulses, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] expAddr;
    int expWords;

    vecs[0] = mkVec(7'b0000011, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, 32'd8, 1'b0, 1'b1, 32'h00812283);
    vecs[1] = mkVec(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd2, 5'd6, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFE612E23);
    vecs[2] = mkVec(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFE208CE3);
`ifdef INST_ENC_RANGE_CHECK_EN
    vecs[3] = mkVec(7'b0010011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'h0);
`else
    vecs[3] = mkVec(7'b0010011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b1, 32'h80000013);
`endif
    vecs[4] = mkVec(7'b1111111, 3'b000, 7'd0, 5'd7, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    vecs[5] = mkVec(7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h002081B3);

    tick(); tick();
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_word_count", {23'd0, word_count}, 32'd0);
    checkOutput("rst_errs", {29'd0, err_imm, err_opcode, err_wrap}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] minimum one-beat session");
    startSession(8'h10);
    v = vecs[0];
    v.last = 1'b1;
    applyStimulus(v);
    checkOutput("min_wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("min_wr_addr", {24'd0, wr_addr}, 32'h10);
    checkOutput("min_wr_data", wr_data, 32'h00812283);
    tick();
    checkOutput("min_written_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("min_word_count", {23'd0, word_count}, 32'd1);
    checkOutput("min_done_early", {31'd0, done}, 32'd0);
    tick();
    checkOutput("min_done", {31'd0, done}, 32'd1);
    tick();
    checkOutput("min_done_gone", {31'd0, done}, 32'd0);
    checkOutput("min_idle", {31'd0, busy}, 32'd0);

    $display("[TB] table-driven stream");
    startSession(8'h20);
    expAddr = 8'h20;
    expWords = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vecs[i].expWrite});
      if (vecs[i].expWrite) begin
        checkOutput($sformatf("vec%0d_wr_addr", i), {24'd0, wr_addr}, {24'd0, expAddr});
        checkOutput($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].expData);
        expAddr = expAddr + 8'd1;
        expWords++;
      end
    end
    waitDone("stream");
    checkOutput("stream_word_count", {23'd0, word_count}, expWords);
    checkOutput("stream_err_opcode", {31'd0, err_opcode}, 32'd1);
`ifdef INST_ENC_RANGE_CHECK_EN
    checkOutput("stream_err_imm", {31'd0, err_imm}, 32'd1);
`else
    checkOutput("stream_err_imm", {31'd0, err_imm}, 32'd0);
`endif
    checkOutput("stream_err_wrap", {31'd0, err_wrap}, 32'd0);
    checkOutput("sat_word_count2", {29'd0, word_count2}, 32'd4);

    $display("[TB] backpressure stall");
    startSession(8'h40);
    checkOutput("stall_err_cleared", {31'd0, err_opcode}, 32'd0);
    checkOutput("stall_count_cleared", {23'd0, word_count}, 32'd0);
    applyStimulus(vecs[0]);
    checkOutput("stall_first_addr", {24'd0, wr_addr}, 32'h40);
    mem_ready = 1'b0;
    driveBeat(vecs[1]);
    start = 1'b1;
    base_addr = 8'h99;
    for (int c = 0; c < 3; c++) begin
      tick();
      start = 1'b0;
      checkOutput($sformatf("stall%0d_wr_en", c), {31'd0, wr_en}, 32'd1);
      checkOutput($sformatf("stall%0d_wr_addr", c), {24'd0, wr_addr}, 32'h40);
      checkOutput($sformatf("stall%0d_wr_data", c), wr_data, 32'h00812283);
      checkOutput($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("resume_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("resume_wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("resume_wr_addr", {24'd0, wr_addr}, 32'h41);
    checkOutput("resume_wr_data", wr_data, 32'hFE612E23);
    checkOutput("resume_word_count", {23'd0, word_count}, 32'd1);
    applyStimulus(vecs[5]);
    checkOutput("resume_last_addr", {24'd0, wr_addr}, 32'h42);
    checkOutput("resume_last_data", wr_data, 32'h002081B3);
    waitDone("stall");
    checkOutput("stall_word_count", {23'd0, word_count}, 32'd3);

    $display("[TB] address wrap on ADDR_W=2 instance");
    startSession(8'h03);
    applyStimulus(vecs[0]);
    checkOutput("wrap_first_addr2", {30'd0, wr_addr2}, 32'd3);
    checkOutput("wrap_err_wrap2", {31'd0, err_wrap2}, 32'd1);
    checkOutput("wrap_err_wrap_wide", {31'd0, err_wrap}, 32'd0);
    applyStimulus(vecs[5]);
    checkOutput("wrap_second_addr2", {30'd0, wr_addr2}, 32'd0);
    checkOutput("wrap_second_data2", wr_data2, 32'h002081B3);
    checkOutput("wrap_second_addr_wide", {24'd0, wr_addr}, 32'h04);
    waitDone("wrap");
    checkOutput("wrap_word_count2", {29'd0, word_count2}, 32'd2);

    $display("[TB] reset mid-session");
    startSession(8'h50);
    mem_ready = 1'b0;
    applyStimulus(vecs[0]);
    checkOutput("abort_pre_wr_en", {31'd0, wr_en}, 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("abort_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("abort_wr_addr", {24'd0, wr_addr}, 32'd0);
    checkOutput("abort_wr_data", wr_data, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("abort_word_count", {23'd0, word_count}, 32'd0);
    checkOutput("abort_errs2", {29'd0, err_imm2, err_opcode2, err_wrap2}, 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RV32I instruction encoder and instruction-memory loader. It accepts decoded instruction fields over a valid/ready input, packs them into 32-bit machine words (R, I-load, I-ALU, S, B), and writes them into instruction memory at consecutive word addresses. It is the write-side counterpart of the core's immediate and field decode, used by the boot/test loader to fill IMEM before the pipeline is released from reset.

## Interface
- `ADDR_W`, 8, IMEM word-address width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load session (honoured in IDLE only).
- `base_addr`  in  ADDR_W  first word address, sampled on accepted `start`.
- `in_valid`  in  1  field beat valid.
- `in_ready`  out  1  encoder can accept a beat.
- `in_last`  in  1  beat is the final one of the session.
- `opcode`  in  7  RV32I opcode.
- `funct3`  in  3  funct3.
- `funct7`  in  7  funct7 (R-type only).
- `rd`, `rs1`, `rs2`  in  5 each  register indices.
- `imm`  in  32  signed immediate; B-type is in halfword units (byte offset / 2), the same convention the core's immediate generation produces.
- `wr_en`  out  1  IMEM write request (output-register valid).
- `mem_ready`  in  1  IMEM accepts the write this cycle.
- `wr_addr`  out  ADDR_W  IMEM word address.
- `wr_data`  out  32  encoded instruction.
- `busy`  out  1  FSM not IDLE.
- `done`  out  1  one-cycle pulse at session end.
- `word_count`  out  ADDR_W+1  words written this session.
- `err_imm`, `err_opcode`, `err_wrap`  out  1 each  sticky error flags.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`: load address counter from `base_addr`, clear `word_count` and all error flags.
  - RUN → DRAIN when a beat with `in_last` is accepted.
  - DRAIN → DONE when the output register is empty.
  - DONE → IDLE unconditionally. `done`=1 only in DONE.
- `start` outside IDLE is ignored.
- Accept: `in_valid && in_ready`. `in_ready` = (state==RUN) && (!wr_en || mem_ready).
- Encoding by opcode:
  - 0110011 R: {funct7,rs2,rs1,funct3,rd,op}.
  - 0000011 / 0010011 I: {imm[11:0],rs1,funct3,rd,op}.
  - 0100011 S: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
  - 1100011 B: inst[31]=imm[11], inst[7]=imm[10], inst[30:25]=imm[9:4], inst[11:8]=imm[3:0].
- Any other opcode: beat consumed, no write, `err_opcode` set.
- Immediate range (I/S/B): -2048..2047 (imm[31:11] all equal); see Configuration.
- Rejected beats do not advance the address or `word_count`. A rejected beat with `in_last` still ends the session.
- Each accepted good beat loads the output register and advances the address by 1 modulo 2^ADDR_W. Advancing from all-ones to 0 sets `err_wrap`; the write still occurs.
- `word_count` increments on each `wr_en && mem_ready` and saturates at 2^ADDR_W.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `word_count`=0, all error flags 0; FSM IDLE.
- Latency: beat accepted at edge N → `wr_en`/`wr_addr`/`wr_data` valid after edge N.
- Full throughput of 1 word/cycle while `mem_ready`=1.
- While `wr_en && !mem_ready`: `wr_addr` and `wr_data` are held stable and `in_ready`=0.
- A simultaneous write completion and new accept in the same cycle leaves `wr_en`=1 with the new word.
- `rst` mid-session aborts immediately; words already written are not undone.
- Minimum session with one beat: `start` at edge 0, accept at edge 1, write at edge 2 (if `mem_ready`), DRAIN → DONE with `done` high after edge 3.

## Configuration
- `INST_ENC_RANGE_CHECK_EN` defined: out-of-range immediates are rejected (beat consumed, no write, `err_imm` set).
- Not defined: no check; imm[11:0] is encoded silently and `err_imm` is tied to 0.

## Test plan
- lw: opcode 0000011, f3=010, rd=5, rs1=2, imm=8, base_addr=0x10 → `wr_data`=0x00812283 at `wr_addr`=0x10.
- Stream of three beats, `mem_ready`=1: sw x6,-4(x2) → 0xFE612E23; beq x1,x2, imm=-4 (halfwords) → 0xFE208CE3; add x3,x1,x2 with `in_last` → 0x002081B3.
  - Addresses increase consecutively, `word_count`=3, one `done` pulse.
- With the macro defined: addi imm=2048 → no `wr_en`, `err_imm`=1, `word_count` unchanged. Without the macro: written as 0x80000013 for rd/rs1=0, f3=0.
- Hold `mem_ready`=0 for 3 cycles mid-stream → `wr_en`/`wr_addr`/`wr_data` stable, `in_ready`=0; resumes with no loss or duplication.
- ADDR_W=2, base_addr=3, two beats → writes at 3 then 0, `err_wrap`=1. Opcode 1111111 → consumed, `err_opcode`=1. Assert `rst` mid-session → all outputs at reset values on the next cycle.
